// File: rtl/team_06_sram_arbiter.sv
// Round-robin arbiter sharing one wishbone_manager CPU port between two SRAM requesters.
// Latency: request seen in IDLE -> strobe next cycle; done one cycle after mgr_busy falls (min 4 cycles).
// Backpressure: requests are levels held until done; mgr_busy high in IDLE blocks any new grant.
module team_06_sram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [3:0]        req0_sel,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_done,
    output logic              req0_busy,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [3:0]        req1_sel,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_done,
    output logic              req1_busy,
    output logic [DATA_W-1:0] mgr_dat_o,
    output logic [ADDR_W-1:0] mgr_adr,
    output logic [3:0]        mgr_sel,
    output logic              mgr_write,
    output logic              mgr_read,
    input  logic [DATA_W-1:0] mgr_dat_i,
    input  logic              mgr_busy,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_grant;
    logic                r_last_grant;
    logic                r_op_wr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_req0_rdata;
    logic [DATA_W-1:0]   r_req1_rdata;
    logic                r_req0_done;
    logic                r_req1_done;
    logic                r_req0_busy;
    logic                r_req1_busy;
    logic [DATA_W-1:0]   r_mgr_dat_o;
    logic [ADDR_W-1:0]   r_mgr_adr;
    logic [3:0]          r_mgr_sel;
    logic                r_mgr_write;
    logic                r_mgr_read;
    logic                r_err_timeout;

    logic                w_req0_any;
    logic                w_req1_any;
    logic                w_grant_vld;
    logic                w_grant;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [3:0]          w_sel_sel;
    logic                w_cnt_last;

    // On a tie the port that did not win last time gets the grant; a lone requester always wins.
    assign w_req0_any  = req0_read | req0_write;
    assign w_req1_any  = req1_read | req1_write;
    assign w_grant_vld = ~mgr_busy & (w_req0_any | w_req1_any);
    assign w_grant     = (w_req0_any & w_req1_any) ? ~r_last_grant : w_req1_any;
    // Write wins when a requester raises both read and write.
    assign w_sel_wr    = w_grant ? req1_write : req0_write;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
    assign w_sel_sel   = w_grant ? req1_sel   : req0_sel;
    assign w_cnt_last  = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode for the strobe / BUSY_O handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_grant_vld) w_next_state = S_ISSUE;
            S_ISSUE:     w_next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (mgr_busy)        w_next_state = S_WAIT_DONE;
                else if (w_cnt_last) w_next_state = S_RESP;
            end
            S_WAIT_DONE: if (!mgr_busy) w_next_state = S_RESP;
            S_RESP:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs: command latch, one-cycle strobe, timeout count, read capture and done/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_op_wr       <= 1'b0;
            r_cnt         <= '0;
            r_req0_rdata  <= '0;
            r_req1_rdata  <= '0;
            r_req0_done   <= 1'b0;
            r_req1_done   <= 1'b0;
            r_req0_busy   <= 1'b0;
            r_req1_busy   <= 1'b0;
            r_mgr_dat_o   <= '0;
            r_mgr_adr     <= '0;
            r_mgr_sel     <= '0;
            r_mgr_write   <= 1'b0;
            r_mgr_read    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_mgr_write   <= 1'b0;
            r_mgr_read    <= 1'b0;
            r_req0_done   <= 1'b0;
            r_req1_done   <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_grant     <= w_grant;
                        r_op_wr     <= w_sel_wr;
                        r_mgr_adr   <= w_sel_addr;
                        r_mgr_dat_o <= w_sel_wdata;
                        r_mgr_sel   <= w_sel_sel;
                        r_mgr_write <= w_sel_wr;
                        r_mgr_read  <= ~w_sel_wr;
                        if (w_grant) r_req1_busy <= 1'b1;
                        else         r_req0_busy <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (!mgr_busy) begin
                        if (w_cnt_last) begin
                            r_err_timeout <= 1'b1;
                            r_req0_done   <= ~r_grant;
                            r_req1_done   <= r_grant;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!mgr_busy) begin
                        r_req0_done <= ~r_grant;
                        r_req1_done <= r_grant;
                        if (!r_op_wr) begin
                            if (r_grant) r_req1_rdata <= mgr_dat_i;
                            else         r_req0_rdata <= mgr_dat_i;
                        end
                    end
                end
                S_RESP: begin
                    r_req0_busy  <= 1'b0;
                    r_req1_busy  <= 1'b0;
                    r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign req0_rdata  = r_req0_rdata;
    assign req0_done   = r_req0_done;
    assign req0_busy   = r_req0_busy;
    assign req1_rdata  = r_req1_rdata;
    assign req1_done   = r_req1_done;
    assign req1_busy   = r_req1_busy;
    assign mgr_dat_o   = r_mgr_dat_o;
    assign mgr_adr     = r_mgr_adr;
    assign mgr_sel     = r_mgr_sel;
    assign mgr_write   = r_mgr_write;
    assign mgr_read    = r_mgr_read;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Directed bench for team_06_sram_arbiter with a small wishbone_manager busy model.
// Latency: each scenario checks strobe and done cycles against hand-computed offsets.
// Backpressure: the manager model holds busy for a programmable number of cycles or never raises it.
module tb_team_06_sram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BT     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_read = 1'b0, req0_write = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic [3:0]        req0_sel = '0;
    logic [DATA_W-1:0] req0_rdata;
    logic              req0_done, req0_busy;
    logic              req1_read = 1'b0, req1_write = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic [3:0]        req1_sel = '0;
    logic [DATA_W-1:0] req1_rdata;
    logic              req1_done, req1_busy;
    logic [DATA_W-1:0] mgr_dat_o;
    logic [ADDR_W-1:0] mgr_adr;
    logic [3:0]        mgr_sel;
    logic              mgr_write, mgr_read;
    logic [DATA_W-1:0] mgr_dat_i = '0;
    logic              mgr_busy;
    logic              err_timeout;

    // manager model state
    logic        m_busy = 1'b0;
    logic        force_busy = 1'b0;
    int          m_hold = 1;
    bit          m_never = 1'b0;
    int          m_cnt = 0;
    int          strobe_cnt = 0;
    int          strobe_cyc = 0;
    logic [31:0] s_adr = '0, s_dat = '0;
    logic [3:0]  s_sel = '0;
    logic        s_wr = 1'b0;
    int          done_log[$];
    bit          multi_done = 1'b0;
    int          cyc = 0;

    int tests = 0;
    int fails = 0;

    assign mgr_busy = m_busy | force_busy;

    team_06_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst),
        .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_sel(req0_sel), .req0_rdata(req0_rdata),
        .req0_done(req0_done), .req0_busy(req0_busy),
        .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_sel(req1_sel), .req1_rdata(req1_rdata),
        .req1_done(req1_done), .req1_busy(req1_busy),
        .mgr_dat_o(mgr_dat_o), .mgr_adr(mgr_adr), .mgr_sel(mgr_sel),
        .mgr_write(mgr_write), .mgr_read(mgr_read),
        .mgr_dat_i(mgr_dat_i), .mgr_busy(mgr_busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Manager: busy rises the cycle after a strobe and stays high m_hold cycles; logs strobes and dones.
    always @(negedge clk) begin
        if (m_cnt > 0) begin
            m_busy = 1'b1;
            m_cnt  = m_cnt - 1;
        end else begin
            m_busy = 1'b0;
        end
        if (mgr_write || mgr_read) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
            s_adr = mgr_adr;
            s_dat = mgr_dat_o;
            s_sel = mgr_sel;
            s_wr  = mgr_write;
            if (!m_never) m_cnt = m_hold;
        end
        if (req0_done) done_log.push_back(0);
        if (req1_done) done_log.push_back(1);
        if (req0_done && req1_done) multi_done = 1'b1;
    end

    task automatic wait_done(input int p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_done) || (p == 1 && req1_done)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({req0_rdata, req1_rdata, mgr_dat_o, mgr_adr} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {req0_rdata, req1_rdata, mgr_dat_o, mgr_adr});
        end
        tests++;
        if ({req0_done, req1_done, req0_busy, req1_busy, mgr_write, mgr_read, err_timeout, mgr_sel} !== 11'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {req0_done, req1_done, req0_busy, req1_busy, mgr_write, mgr_read, err_timeout, mgr_sel});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (strobe_cnt !== 0) begin
            fails++;
            $display("FAIL reset_idle_strobe: got %0d expected 0", strobe_cnt);
        end
    endtask

    task automatic test_single_write();
        int t, n;
        bit ok;
        m_hold = 3;
        n = strobe_cnt;
        req0_write = 1'b1; req0_addr = 32'h40; req0_wdata = 32'hA5; req0_sel = 4'hF;
        t = cyc;
        @(negedge clk);
        tests++;
        if ({mgr_write, mgr_read, req0_busy} !== 3'b101) begin
            fails++;
            $display("FAIL wr_strobe: got %b expected 101", {mgr_write, mgr_read, req0_busy});
        end
        wait_done(0, 20, ok);
        req0_write = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wr_done_timeout: got no done expected done");
        end
        // strobe t+1, busy t+2..t+4, low at t+5, done at t+6
        tests++;
        if (cyc !== t + 6) begin
            fails++;
            $display("FAIL wr_done_cycle: got %0d expected %0d", cyc - t, 6);
        end
        tests++;
        if (err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL wr_err: got %b expected 0", err_timeout);
        end
        tests++;
        if ({s_wr, s_adr, s_dat, s_sel, 32'(strobe_cnt - n)} !== {1'b1, 32'h40, 32'hA5, 4'hF, 32'd1}) begin
            fails++;
            $display("FAIL wr_cmd: got wr=%b adr=%h dat=%h sel=%h n=%0d expected 1 40 a5 f 1",
                     s_wr, s_adr, s_dat, s_sel, strobe_cnt - n);
        end
        @(negedge clk);
        tests++;
        if ({req0_done, req0_busy} !== 2'b00) begin
            fails++;
            $display("FAIL wr_after_done: got %b expected 00", {req0_done, req0_busy});
        end
    endtask

    task automatic test_single_read();
        int t;
        bit ok;
        m_hold = 1;
        mgr_dat_i = 32'h1234_5678;
        req1_read = 1'b1; req1_addr = 32'h80; req1_sel = 4'hF;
        t = cyc;
        wait_done(1, 20, ok);
        req1_read = 1'b0;
        tests++;
        if (!ok || cyc !== t + 4) begin
            fails++;
            $display("FAIL rd_done_cycle: got ok=%b dt=%0d expected ok=1 dt=4", ok, cyc - t);
        end
        tests++;
        if (req1_rdata !== 32'h1234_5678 || req0_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rd_data: got r1=%h r0=%h expected 12345678 0", req1_rdata, req0_rdata);
        end
        tests++;
        if ({s_wr, s_adr} !== {1'b0, 32'h80}) begin
            fails++;
            $display("FAIL rd_cmd: got wr=%b adr=%h expected 0 80", s_wr, s_adr);
        end
        mgr_dat_i = 32'h0;
        repeat (2) @(negedge clk);
        tests++;
        if (req1_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL rd_hold: got %h expected 12345678", req1_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_hold = 2;
        base = done_log.size();
        req0_write = 1'b1; req0_addr = 32'h100; req0_wdata = 32'h11;
        req1_read  = 1'b1; req1_addr = 32'h200;
        for (int i = 0; i < 40 && (req0_write || req1_read); i++) begin
            @(negedge clk);
            if (req0_done) req0_write = 1'b0;
            if (req1_done) req1_read = 1'b0;
        end
        req0_write = 1'b0; req1_read = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (done_log.size() - base !== 2 || done_log[base] !== 0 || done_log[base+1] !== 1) begin
            fails++;
            $display("FAIL sim_order: got n=%0d first=%0d expected n=2 order 0,1",
                     done_log.size() - base, (done_log.size() > base) ? done_log[base] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int base, n0, n1;
        logic [3:0] ord;
        base = done_log.size();
        n0 = 0; n1 = 0;
        req0_read = 1'b1; req0_addr = 32'h400;
        req1_write = 1'b1; req1_addr = 32'h500; req1_wdata = 32'h22;
        for (int i = 0; i < 80 && (req0_read || req1_write); i++) begin
            @(negedge clk);
            if (req0_done) begin n0++; if (n0 == 2) req0_read = 1'b0; end
            if (req1_done) begin n1++; if (n1 == 2) req1_write = 1'b0; end
        end
        req0_read = 1'b0; req1_write = 1'b0;
        repeat (5) @(negedge clk);
        ord = 4'hF;
        for (int i = 0; i < 4; i++)
            if (done_log.size() > base + i) ord[3-i] = done_log[base+i][0];
        tests++;
        if (done_log.size() - base !== 4 || ord !== 4'b0101) begin
            fails++;
            $display("FAIL b2b_order: got n=%0d order=%b expected n=4 order=0101", done_log.size() - base, ord);
        end
    endtask

    task automatic test_timeout();
        int t;
        bit ok;
        m_hold = 1;
        mgr_dat_i = 32'hCAFE_F00D;
        req0_read = 1'b1; req0_addr = 32'h300;
        wait_done(0, 20, ok);
        req0_read = 1'b0;
        tests++;
        if (!ok || req0_rdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL to_preload: got ok=%b r0=%h expected 1 cafef00d", ok, req0_rdata);
        end
        @(negedge clk);
        m_never = 1'b1;
        mgr_dat_i = 32'hDEAD_BEEF;
        req0_read = 1'b1; req0_addr = 32'h304;
        t = cyc;
        wait_done(0, BT + 10, ok);
        req0_read = 1'b0;
        // strobe at t+1, abort done at t+1+BT+1
        tests++;
        if (!ok || cyc !== t + BT + 2) begin
            fails++;
            $display("FAIL to_done_cycle: got ok=%b dt=%0d expected ok=1 dt=%0d", ok, cyc - t, BT + 2);
        end
        tests++;
        if (err_timeout !== 1'b1 || req0_rdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL to_err_data: got err=%b r0=%h expected 1 cafef00d", err_timeout, req0_rdata);
        end
        @(negedge clk);
        tests++;
        if ({err_timeout, req0_done, req0_busy} !== 3'b000) begin
            fails++;
            $display("FAIL to_after: got %b expected 000", {err_timeout, req0_done, req0_busy});
        end
        m_never = 1'b0;
    endtask

    task automatic test_busy_block();
        int n, u;
        bit ok;
        m_hold = 1;
        n = strobe_cnt;
        force_busy = 1'b1;
        req0_write = 1'b1; req0_addr = 32'h44; req0_wdata = 32'h55; req0_sel = 4'h3;
        repeat (5) @(negedge clk);
        tests++;
        if (strobe_cnt !== n || req0_busy !== 1'b0) begin
            fails++;
            $display("FAIL blk_hold: got strobes=%0d busy=%b expected 0 0", strobe_cnt - n, req0_busy);
        end
        force_busy = 1'b0;
        u = cyc;
        wait_done(0, 20, ok);
        req0_write = 1'b0;
        tests++;
        if (!ok || strobe_cyc !== u + 1 || s_adr !== 32'h44 || cyc !== u + 4) begin
            fails++;
            $display("FAIL blk_release: got ok=%b strobe_dt=%0d done_dt=%0d adr=%h expected 1 1 4 44",
                     ok, strobe_cyc - u, cyc - u, s_adr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        m_hold = 1;
        req0_write = 1'b1; req0_addr = 32'h10;
        wait_done(0, 20, ok);
        req0_write = 1'b0;
        @(negedge clk);
        m_hold = 6;
        req1_read = 1'b1; req1_addr = 32'h20;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req1_read = 1'b0;
        #1;
        tests++;
        if ({req0_rdata, req1_rdata, mgr_dat_o, mgr_adr, req0_done, req1_done, req0_busy, req1_busy,
             mgr_write, mgr_read, err_timeout, mgr_sel} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got busy=%b%b adr=%h r0=%h r1=%h expected all 0",
                     req0_busy, req1_busy, mgr_adr, req0_rdata, req1_rdata);
        end
        repeat (8) @(negedge clk);
        rst = 1'b0;
        m_hold = 1;
        base = done_log.size();
        req0_write = 1'b1; req0_addr = 32'h30;
        req1_read  = 1'b1; req1_addr = 32'h34;
        for (int i = 0; i < 40 && (req0_write || req1_read); i++) begin
            @(negedge clk);
            if (req0_done) req0_write = 1'b0;
            if (req1_done) req1_read = 1'b0;
        end
        req0_write = 1'b0; req1_read = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (done_log.size() - base !== 2 || done_log[base] !== 0) begin
            fails++;
            $display("FAIL rst_mid_priority: got n=%0d first=%0d expected n=2 first=0",
                     done_log.size() - base, (done_log.size() > base) ? done_log[base] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_busy_block();
        test_reset_mid();
        tests++;
        if (multi_done !== 1'b0) begin
            fails++;
            $display("FAIL one_done_per_cycle: got both dones together expected at most one");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
